// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader: unpacks a stream of pixel bytes LSB-first into a 1-bit sprite RAM
// that the renderer reads through a registered, read-before-write port.
module sprite_ram_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] read_address,
    output logic          pixel_out,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, FETCH, UNPACK, DONE} state_t;
    localparam logic [AW-4:0] LAST = (AW-3)'(DEPTH/8-1);
    state_t        state, state_n;
    logic [AW-4:0] byte_idx;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          mem [DEPTH];
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? FETCH : IDLE;
            FETCH:   state_n = in_valid ? UNPACK : FETCH;
            UNPACK:  state_n = bit_idx != 3'd7 ? UNPACK : (byte_idx == LAST ? DONE : FETCH);
            default: state_n = IDLE;
        endcase
    end
    assign in_ready = state == FETCH;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            byte_idx  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            pixel_out <= 1'b0;
        end else begin
            state     <= state_n;
            pixel_out <= mem[read_address];
            if (state == IDLE && start) begin
                byte_idx <= '0;
                bit_idx  <= '0;
            end
            if (state == FETCH && in_valid) shift <= in_data;
            if (state == UNPACK) begin
                bit_idx <= bit_idx + 3'd1;
                // hold on the last byte so the index never wraps inside a load
                if (bit_idx == 3'd7 && byte_idx != LAST) byte_idx <= byte_idx + 1'b1;
            end
        end
    end
    // no reset on the array: contents survive Reset, only the write strobe is gated
    always_ff @(posedge Clk) begin
        if (!Reset && state == UNPACK) mem[{byte_idx, bit_idx}] <= shift[bit_idx];
    end
endmodule

// File: tb/tb_sprite_ram_loader.sv
// tb_sprite_ram_loader: directed, table-driven checks of loading, readback, reset abort
// and same-address read-before-write behaviour.
module tb_sprite_ram_loader;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    logic          Clk = 1'b0;
    logic          Reset, start, in_valid, in_ready, pixel_out, busy, done;
    logic [7:0]    in_data;
    logic [AW-1:0] read_address;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [7:0]    pat [128];

    typedef struct {
        int addr;
        int exp;
    } vec_t;
    vec_t vecs [13];

    sprite_ram_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .read_address(read_address), .pixel_out(pixel_out),
        .busy(busy), .done(done)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic finish_sim;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic rd(input int a, input int exp, input string name);
        read_address = AW'(a);
        tick;
        chk(name, int'(pixel_out), exp);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 128; i++) pat[i] = v;
    endtask

    // Loads nbytes of pat; garbage with in_valid=1 is driven while not ready.
    task automatic load(input int nbytes, input bit sparse, input int start_at,
                        input int watch_byte, input int old_v);
        bit acc;
        start = 1'b1;
        in_valid = 1'b0;
        tick;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (int b = 0; b < nbytes; b++) begin
            if (watch_byte == b) read_address = AW'(b * 8);
            acc = 1'b0;
            for (int w = 0; w < 12 && !acc; w++) begin
                in_valid = sparse ? (cyc % 3 == 0) : 1'b1;
                in_data  = pat[b];
                chk("in_ready_fetch", int'(in_ready), 1);
                acc = in_valid;
                tick;
            end
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                finish_sim();
            end
            for (int k = 0; k < 8; k++) begin
                in_valid = 1'b1;
                in_data  = ~pat[b];
                start    = (b == start_at && k == 3);
                chk("in_ready_unpack", int'(in_ready), 0);
                chk("done_early", int'(done), 0);
                chk("busy_unpack", int'(busy), 1);
                if (b == watch_byte)
                    chk("same_addr_read", int'(pixel_out), k < 2 ? old_v : int'(pat[b][0]));
                tick;
            end
            start = 1'b0;
            in_valid = 1'b0;
        end
        if (nbytes == 128) begin
            chk("done_pulse", int'(done), 1);
            chk("busy_done", int'(busy), 1);
            tick;
            chk("done_once", int'(done), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_ready", int'(in_ready), 0);
        end
    endtask

    initial begin
        vecs[0] = '{0, 1};    vecs[1] = '{8, 1};    vecs[2] = '{1016, 1};
        vecs[3] = '{1, 0};    vecs[4] = '{1023, 0}; vecs[5] = '{24, 1};
        vecs[6] = '{25, 0};   vecs[7] = '{26, 1};   vecs[8] = '{27, 0};
        vecs[9] = '{28, 0};   vecs[10] = '{29, 1};  vecs[11] = '{30, 0};
        vecs[12] = '{31, 1};
        Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; read_address = '0;
        tick;
        tick;
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pixel", int'(pixel_out), 0);
        Reset = 1'b0;
        tick;

        fill(8'h01);
        pat[3] = 8'hA5;
        load(128, 1'b0, -1, -1, 0);
        foreach (vecs[i]) rd(vecs[i].addr, vecs[i].exp, "image_vec");

        fill(8'h00);
        load(128, 1'b0, -1, 5, 1);
        rd(40, 0, "addr40_cleared");
        rd(24, 0, "addr24_cleared");

        fill(8'h01);
        pat[3] = 8'hA5;
        load(128, 1'b1, 10, -1, 0);
        for (int a = 0; a < DEPTH; a++) rd(a, int'(pat[a / 8][a % 8]), "sparse_image");

        fill(8'h00);
        load(128, 1'b0, -1, -1, 0);
        fill(8'hFF);
        load(50, 1'b0, -1, -1, 0);
        in_valid = 1'b1;
        in_data = 8'hFF;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        Reset = 1'b1;
        start = 1'b1;
        in_valid = 1'b1;
        read_address = '0;
        tick;
        chk("abort_pixel", int'(pixel_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(in_ready), 0);
        chk("abort_done", int'(done), 0);
        Reset = 1'b0;
        start = 1'b0;
        repeat (4) begin
            tick;
            chk("post_abort_idle", int'(busy), 0);
        end
        in_valid = 1'b0;
        for (int a = 0; a < DEPTH; a++)
            if (a != 403) rd(a, a < 403 ? 1 : 0, "abort_image");

        load(128, 1'b0, -1, -1, 0);
        for (int a = 0; a < DEPTH; a++) rd(a, 1, "ff_image");
        finish_sim();
    end
endmodule
